// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the MEM-stage data-memory sequencer
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } dmem_state_t;

  // Size code 3 is not a legal enum value and lands in the default word case.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
    case (mem_size_t'(sz))
      MEM_B:   return 3'd1;
      MEM_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_seq_if.sv
// rtl/dmem_seq_if.sv - request, response and byte-SRAM signals of the sequencer
interface dmem_seq_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 4
);
  logic              i_valid;
  logic              i_flush;
  logic              i_we;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;
  logic              o_ready;
  logic [CNT_W-1:0]  o_mem_data_access;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        o_mem_wdata;
  logic [7:0]        i_mem_rdata;
  logic [31:0]       o_rdata;
  logic              o_rdata_valid;
  logic              o_st_done;

  modport slave (
    input  i_valid, i_flush, i_we, i_size, i_unsigned, i_addr, i_wdata, i_mem_rdata,
    output o_ready, o_mem_data_access, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
           o_rdata, o_rdata_valid, o_st_done
  );

  modport master (
    output i_valid, i_flush, i_we, i_size, i_unsigned, i_addr, i_wdata, i_mem_rdata,
    input  o_ready, o_mem_data_access, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
           o_rdata, o_rdata_valid, o_st_done
  );
endinterface

// File: rtl/load_ext.sv
// rtl/load_ext.sv - sign/zero extension of a 1, 2 or 4 byte load value
module load_ext (
  input  logic [31:0] i_data,
  input  logic [2:0]  i_nbytes,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);
  // Replicate the top bit of the loaded field unless zero-extension is requested.
  always_comb begin
    o_data = i_data;
    case (i_nbytes)
      3'd1:    o_data = {{24{i_data[7]  & ~i_unsigned}}, i_data[7:0]};
      3'd2:    o_data = {{16{i_data[15] & ~i_unsigned}}, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end
endmodule

// File: rtl/dmem_seq.sv
// rtl/dmem_seq.sv - splits loads/stores into byte beats on an 8-bit SRAM port
module dmem_seq
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 4
) (
  input logic       clk,
  input logic       rst,
  dmem_seq_if.slave bus
);

  dmem_state_t       r_state, w_next;
  logic              w_accept, w_ready, w_rvalid, w_stdone, w_last;
  logic [CNT_W-1:0]  w_access;
  logic [2:0]        w_n;
  logic              r_we, r_unsigned;
  logic [2:0]        r_nbytes;
  logic [1:0]        r_beat, r_last_beat;
  logic [23:0]       r_wsh;
  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_rd_pend;
  logic [1:0]        r_rd_idx;
  logic [31:0]       r_asm, w_asm_next, w_ext, r_rdata;
  logic [4:0]        w_sh;

  assign w_last = (r_beat == r_last_beat);
  assign w_sh   = {r_rd_idx, 3'b000};

  // Drop the byte returned for the previous cycle's read into its lane.
  assign w_asm_next = r_rd_pend
      ? ((r_asm & ~(32'hFF << w_sh)) | ({24'h0, bus.i_mem_rdata} << w_sh))
      : r_asm;

  load_ext u_ext (
    .i_data     (w_asm_next),
    .i_nbytes   (r_nbytes),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state, acceptance, stall-controller count and completion pulses.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_ready  = 1'b0;
    w_access = '0;
    w_rvalid = 1'b0;
    w_stdone = 1'b0;
    w_n      = size_to_bytes(bus.i_size);
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.i_valid && !bus.i_flush) begin
          w_accept = 1'b1;
          w_access = CNT_W'(w_n) + CNT_W'(!bus.i_we);
          w_next   = ST_ACCESS;
        end
      end
      ST_ACCESS: if (w_last) w_next = r_we ? ST_DONE : ST_DRAIN;
      ST_DRAIN:  w_next = ST_DONE;
      ST_DONE: begin
        w_next   = ST_IDLE;
        w_rvalid = !r_we;
        w_stdone = r_we;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // Request latch, beat generation and load-byte assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_nbytes    <= 3'd0;
      r_beat      <= 2'd0;
      r_last_beat <= 2'd0;
      r_wsh       <= 24'h0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h0;
      r_rd_pend   <= 1'b0;
      r_rd_idx    <= 2'd0;
      r_asm       <= 32'h0;
      r_rdata     <= 32'h0;
    end else begin
      r_rd_pend <= r_mem_en && !r_mem_we;
      r_rd_idx  <= r_beat;
      r_asm     <= w_asm_next;
      if (r_state == ST_DRAIN) r_rdata <= w_ext;
      if (w_accept) begin
        r_we        <= bus.i_we;
        r_unsigned  <= bus.i_unsigned;
        r_nbytes    <= w_n;
        r_last_beat <= 2'(w_n - 3'd1);
        r_beat      <= 2'd0;
        r_wsh       <= bus.i_wdata[31:8];
        r_mem_en    <= 1'b1;
        r_mem_we    <= bus.i_we;
        r_mem_addr  <= bus.i_addr;
        r_mem_wdata <= bus.i_wdata[7:0];
        r_asm       <= 32'h0;
      end else if (r_state == ST_ACCESS) begin
        if (w_last) begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end else begin
          r_beat      <= r_beat + 2'd1;
          r_mem_addr  <= r_mem_addr + 1'b1;
          r_mem_wdata <= r_wsh[7:0];
          r_wsh       <= r_wsh >> 8;
        end
      end
    end
  end

  assign bus.o_ready           = w_ready;
  assign bus.o_mem_data_access = w_access;
  assign bus.o_mem_en          = r_mem_en;
  assign bus.o_mem_we          = r_mem_we;
  assign bus.o_mem_addr        = r_mem_addr;
  assign bus.o_mem_wdata       = r_mem_wdata;
  assign bus.o_rdata           = r_rdata;
  assign bus.o_rdata_valid     = w_rvalid;
  assign bus.o_st_done         = w_stdone;

endmodule

// File: tb/tb_dmem_seq.sv
// tb/tb_dmem_seq.sv - directed table-driven bench for dmem_seq
module tb_dmem_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_seq_if #(.ADDR_W(32), .CNT_W(4)) bus ();

  dmem_seq #(.ADDR_W(32), .CNT_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [logic [31:0]];

  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) mem[bus.o_mem_addr] = bus.o_mem_wdata;
      else bus.i_mem_rdata <= mem.exists(bus.o_mem_addr) ? mem[bus.o_mem_addr] : 8'h00;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  acc;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_we = 1'b0;
    bus.i_size = 2'd0;
    bus.i_unsigned = 1'b0;
    bus.i_addr = 32'h0;
    bus.i_wdata = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b0;
    bus.i_we = v.we;
    bus.i_size = v.size;
    bus.i_unsigned = v.uns;
    bus.i_addr = v.addr;
    bus.i_wdata = v.data;
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int c;
    n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    c = int'(v.acc);
    if (!v.we) for (int k = 0; k < n; k++) mem[v.addr + 32'(k)] = v.data[8*k +: 8];
    drive(v);
    #1;
    chk("accept_ready", 32'(bus.o_ready), 32'd1);
    chk("access_count", 32'(bus.o_mem_data_access), 32'(v.acc));
    step();
    idle_inputs();
    for (int t = 1; t <= c + 1; t++) begin
      chk("mem_en", 32'(bus.o_mem_en), 32'(t <= n));
      if (t <= n) begin
        chk("mem_addr", bus.o_mem_addr, v.addr + 32'(t - 1));
        chk("mem_we", 32'(bus.o_mem_we), 32'(v.we));
        if (v.we) chk("mem_wdata", 32'(bus.o_mem_wdata), 32'(v.data[8*(t-1) +: 8]));
      end
      chk("rdata_valid", 32'(bus.o_rdata_valid), 32'(!v.we && t == c + 1));
      chk("st_done", 32'(bus.o_st_done), 32'(v.we && t == c + 1));
      if (!v.we && t == c + 1) chk("rdata", bus.o_rdata, v.exp_rdata);
      step();
    end
    chk("ready_after", 32'(bus.o_ready), 32'd1);
    if (v.we) for (int k = 0; k < n; k++)
      chk("sram_byte", 32'(mem.exists(v.addr + 32'(k)) ? mem[v.addr + 32'(k)] : 8'hXX), 32'(v.data[8*k +: 8]));
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'h4433_2211, 4'd5, 32'h4433_2211};
    vecs[0].size = 2'd2;
    vecs[1] = '{1'b0, 2'd0, 1'b0, 32'h0000_0007, 32'h0000_0080, 4'd2, 32'hFFFF_FF80};
    vecs[2] = '{1'b0, 2'd0, 1'b1, 32'h0000_0007, 32'h0000_0080, 4'd2, 32'h0000_0080};
    vecs[3] = '{1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_BEEF, 4'd2, 32'h0};
    vecs[4] = '{1'b0, 2'd1, 1'b0, 32'h0000_0201, 32'h0000_9234, 4'd3, 32'hFFFF_9234};
    vecs[5] = '{1'b0, 2'd3, 1'b1, 32'h0000_0300, 32'h8403_0201, 4'd5, 32'h8403_0201};
    vecs[6] = '{1'b1, 2'd0, 1'b0, 32'h0000_0400, 32'h0000_005A, 4'd1, 32'h0};
    vecs[7] = '{1'b1, 2'd2, 1'b0, 32'h0000_0401, 32'h1122_3344, 4'd4, 32'h0};

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_en", 32'(bus.o_mem_en), 32'd0);
    chk("rst_we", 32'(bus.o_mem_we), 32'd0);
    chk("rst_addr", bus.o_mem_addr, 32'h0);
    chk("rst_rdata", bus.o_rdata, 32'h0);
    chk("rst_rvalid", 32'(bus.o_rdata_valid), 32'd0);
    chk("rst_stdone", 32'(bus.o_st_done), 32'd0);
    chk("rst_access", 32'(bus.o_mem_data_access), 32'd0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);
    chk("rdata_hold", bus.o_rdata, 32'h8403_0201);

    // Flushed request in IDLE is not accepted.
    drive(vecs[1]);
    bus.i_flush = 1'b1;
    #1;
    chk("flush_access", 32'(bus.o_mem_data_access), 32'd0);
    step();
    idle_inputs();
    chk("flush_en", 32'(bus.o_mem_en), 32'd0);
    chk("flush_ready", 32'(bus.o_ready), 32'd1);

    // Request held through a busy load is taken the cycle after DONE.
    drive(vecs[1]);
    step();
    bus.i_valid = 1'b1;
    bus.i_we = 1'b1;
    bus.i_size = 2'd0;
    bus.i_addr = 32'h0000_0500;
    bus.i_wdata = 32'h0000_0077;
    #1;
    chk("busy_access_t1", 32'(bus.o_mem_data_access), 32'd0);
    chk("busy_ready_t1", 32'(bus.o_ready), 32'd0);
    step();
    chk("busy_access_t2", 32'(bus.o_mem_data_access), 32'd0);
    step();
    chk("busy_access_done", 32'(bus.o_mem_data_access), 32'd0);
    chk("busy_rvalid_done", 32'(bus.o_rdata_valid), 32'd1);
    chk("busy_rdata_done", bus.o_rdata, 32'hFFFF_FF80);
    step();
    chk("held_access", 32'(bus.o_mem_data_access), 32'd1);
    step();
    idle_inputs();
    chk("held_en", 32'(bus.o_mem_en), 32'd1);
    chk("held_addr", bus.o_mem_addr, 32'h0000_0500);
    step();
    chk("held_stdone", 32'(bus.o_st_done), 32'd1);
    step();
    chk("held_sram", 32'(mem.exists(32'h500) ? mem[32'h500] : 8'hXX), 32'h77);

    // Reset in the middle of a word load aborts it silently.
    drive(vecs[0]);
    step();
    idle_inputs();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_en", 32'(bus.o_mem_en), 32'd0);
    chk("abort_ready", 32'(bus.o_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int t = 0; t < 6; t++) begin
        if (bus.o_rdata_valid || bus.o_st_done || bus.o_mem_en) seen++;
        step();
      end
      chk("abort_no_pulse", 32'(seen), 32'd0);
    end
    run_txn(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
